// File: rtl/pwm_duty_ramp_ctrl.sv
// Slew-limited duty sequencer for the motor PWM generator: ramps the duty toward
// the enabled target on PWM period boundaries, with soft stop and latched fault.
module pwm_duty_ramp_ctrl #(
  parameter int unsigned STEP             = 8,
  parameter int unsigned PERIODS_PER_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [10:0] target,
  input  logic        PWM_synch,
  input  logic        fault,
  input  logic        fault_clr,
  output logic [10:0] duty,
  output logic        at_target,
  output logic        ramping,
  output logic        fault_latched
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0]  PCNT_LAST = 8'(PERIODS_PER_STEP - 1);
  localparam logic [10:0] STEP_L    = 11'(STEP);

  state_t      state, state_next;
  logic [10:0] duty_next;
  logic [7:0]  pcnt, pcnt_next;

  logic [10:0] eff;
  logic        eff_above;
  logic [10:0] mag;
  logic [10:0] step_amt;
  logic [10:0] stepped;
  logic        active;
  logic        update;

  // Magnitude of the error always fits 11 bits, so the step can neither wrap
  // below 0 nor exceed 2047, and it is clamped to the error to avoid overshoot.
  always_comb begin
    eff       = en ? target : 11'd0;
    eff_above = (eff > duty);
    mag       = eff_above ? (eff - duty) : (duty - eff);
    step_amt  = (mag > STEP_L) ? STEP_L : mag;
    stepped   = eff_above ? (duty + step_amt) : (duty - step_amt);
    active    = (state == RAMP) || (state == HOLD);
    update    = active && PWM_synch && (pcnt == PCNT_LAST);
  end

  always_comb begin
    state_next = state;
    duty_next  = duty;
    pcnt_next  = pcnt;
    if (fault) begin
      state_next = FAULT;
      duty_next  = 11'd0;
      pcnt_next  = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          duty_next = 11'd0;
          pcnt_next = 8'd0;
          if (en && (target != 11'd0)) begin
            state_next = RAMP;
          end
        end
        RAMP, HOLD: begin
          if (PWM_synch) begin
            pcnt_next = (pcnt == PCNT_LAST) ? 8'd0 : pcnt + 8'd1;
          end
          if (update) begin
            duty_next = stepped;
            if (stepped == eff) begin
              state_next = (eff == 11'd0) ? IDLE : HOLD;
            end else begin
              state_next = RAMP;
            end
          end
        end
        FAULT: begin
          duty_next = 11'd0;
          pcnt_next = 8'd0;
          if (fault_clr) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          duty_next  = 11'd0;
          pcnt_next  = 8'd0;
        end
      endcase
    end
  end

  // Flags are registered from the next state so they align with duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      duty          <= 11'd0;
      pcnt          <= 8'd0;
      at_target     <= 1'b0;
      ramping       <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_next;
      duty          <= duty_next;
      pcnt          <= pcnt_next;
      at_target     <= (state_next == HOLD);
      ramping       <= (state_next == RAMP);
      fault_latched <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Scoreboard bench for pwm_duty_ramp_ctrl: a behavioural model predicts every
// cycle's outputs, a monitor pops and compares them one clock later.
module tb_pwm_duty_ramp_ctrl;

  localparam int STEP = 8;
  localparam int PPS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] target = 11'd0;
  logic        PWM_synch = 1'b0;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic [10:0] duty;
  logic        at_target;
  logic        ramping;
  logic        fault_latched;

  pwm_duty_ramp_ctrl #(.STEP(STEP), .PERIODS_PER_STEP(PPS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .target(target), .PWM_synch(PWM_synch),
    .fault(fault), .fault_clr(fault_clr), .duty(duty), .at_target(at_target),
    .ramping(ramping), .fault_latched(fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit at_target;
    bit ramping;
    bit flt;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: duty moves toward eff by at most STEP every PPS-th synch
  // while active; "hold" means the last update landed on eff.
  int m_duty;
  bit m_active, m_hold, m_fault;
  int m_per;

  task automatic model_reset();
    m_duty = 0; m_active = 0; m_hold = 0; m_fault = 0; m_per = 0;
  endtask

  task automatic model_step(bit e, int tg, bit s, bit f, bit c);
    int eff, delta, old;
    eff = e ? tg : 0;
    if (f) begin
      if (!m_fault) $display("txn t=%0t fault entry duty %0d -> 0", $time, m_duty);
      m_fault = 1; m_active = 0; m_hold = 0; m_duty = 0; m_per = 0;
    end else if (m_fault) begin
      if (c) begin
        m_fault = 0;
        $display("txn t=%0t fault cleared", $time);
      end
    end else if (!m_active) begin
      if (e && tg != 0) begin
        m_active = 1; m_hold = 0; m_per = 0;
      end
    end else if (s) begin
      m_per++;
      if (m_per == PPS) begin
        m_per = 0;
        old = m_duty;
        delta = eff - m_duty;
        if (delta > STEP) delta = STEP;
        if (delta < -STEP) delta = -STEP;
        m_duty = m_duty + delta;
        $display("txn t=%0t update eff=%0d duty %0d -> %0d", $time, eff, old, m_duty);
        if (m_duty == eff) begin
          if (eff == 0) m_active = 0;
          else m_hold = 1;
        end else begin
          m_hold = 0;
        end
      end
    end
  endtask

  int gap = 6;
  int phase = 0;
  bit rand_synch = 0;
  bit arm_fault = 0;

  task automatic run(int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rand_synch) PWM_synch = ($urandom_range(0, 3) == 0);
      else begin
        PWM_synch = (phase == 0);
        phase = (phase + 1) % gap;
      end
      if (arm_fault && m_active && PWM_synch && m_per == PPS - 1) begin
        fault = 1'b1;
        arm_fault = 0;
      end
      model_step(en, int'(target), PWM_synch, fault, fault_clr);
      e.duty = m_duty;
      e.at_target = m_active && m_hold;
      e.ramping = m_active && !m_hold;
      e.flt = m_fault;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_until_duty(string name, int d, int max_cycles);
    for (int i = 0; i < max_cycles && m_duty != d; i++) run(1);
    check(name, int'(duty), d);
  endtask

  task automatic check_flags(string name, bit a, bit r, bit f);
    check({name, "_at_target"}, int'(at_target), int'(a));
    check({name, "_ramping"}, int'(ramping), int'(r));
    check({name, "_fault_latched"}, int'(fault_latched), int'(f));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("duty", int'(duty), e.duty);
        check("at_target", int'(at_target), int'(e.at_target));
        check("ramping", int'(ramping), int'(e.ramping));
        check("fault_latched", int'(fault_latched), int'(e.flt));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_duty", int'(duty), 0);
    check_flags("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with en low: synch pulses must not move duty.
    target = 11'd500;
    run(20 * gap);
    check("idle_duty", int'(duty), 0);

    // Ramp up in exact multiples to 40.
    en = 1'b1; target = 11'd40;
    run(21 * gap);
    check("ramp40_duty", int'(duty), 40);
    check_flags("ramp40", 1, 0, 0);

    // Final partial step, then full-scale ramp with a last step of 4.
    target = 11'd43;
    run((PPS + 1) * gap);
    check("ramp43_duty", int'(duty), 43);
    target = 11'd2047;
    run_until_duty("reach_2047", 2047, 252 * PPS * gap);
    run(gap);
    check_flags("full", 1, 0, 0);

    // Soft stop all the way down to IDLE.
    en = 1'b0;
    run_until_duty("reach_0", 0, 257 * PPS * gap);
    run(gap);
    check_flags("stopped", 0, 0, 0);

    // Mid-ramp reversal.
    en = 1'b1; target = 11'd100;
    run_until_duty("reach_48", 48, 10 * PPS * gap);
    target = 11'd20;
    run(6 * PPS * gap);
    check("reversal_duty", int'(duty), 20);
    check_flags("reversal", 1, 0, 0);

    // Soft stop interrupted by re-enable at 16.
    target = 11'd40;
    run_until_duty("reach_40", 40, 5 * PPS * gap);
    en = 1'b0;
    run_until_duty("softstop_16", 16, 5 * PPS * gap);
    check("softstop_ramping", int'(ramping), 1);
    en = 1'b1;
    run_until_duty("resume_40", 40, 5 * PPS * gap);
    run(gap);
    check_flags("resume", 1, 0, 0);

    // Fault coinciding with an update instant at duty 24.
    en = 1'b0;
    run_until_duty("fault_24", 24, 5 * PPS * gap);
    arm_fault = 1;
    for (int i = 0; i < 2 * PPS * gap && !fault; i++) run(1);
    check("fault_armed", int'(fault), 1);
    check("fault_duty", int'(duty), 0);
    check_flags("fault", 0, 0, 1);
    arm_fault = 0;
    fault_clr = 1'b1; run(1); fault_clr = 1'b0;
    run(3);
    check("clr_ignored", int'(fault_latched), 1);
    fault = 1'b0;
    run(3);
    check("still_latched", int'(fault_latched), 1);
    fault_clr = 1'b1; run(1); fault_clr = 1'b0;
    run(2);
    check("cleared_duty", int'(duty), 0);
    check_flags("cleared", 0, 0, 0);

    // Asynchronous reset mid-ramp at duty 32.
    en = 1'b1; target = 11'd100;
    run_until_duty("reach_32", 32, 8 * PPS * gap);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_duty", int'(duty), 0);
    check_flags("areset", 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0; target = 11'd300;
    run(20 * gap);
    check("post_reset_idle", int'(duty), 0);

    // Randomized stress against the model.
    rand_synch = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: target = 11'd0;
          1: target = 11'd2047;
          2: target = 11'($urandom_range(1, 60));
          default: target = 11'($urandom_range(0, 2047));
        endcase
      end
      if (!fault && $urandom_range(0, 299) == 0) fault = 1'b1;
      else if (fault && $urandom_range(0, 9) == 0) fault = 1'b0;
      fault_clr = ($urandom_range(0, 19) == 0);
      run(1);
    end
    fault_clr = 1'b0; fault = 1'b0; rand_synch = 0;
    run(5);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
